// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded operands with MEM/WB bypass, holds under back-pressure
// while snooping WB writes. Optional statistics counters are enabled by defining ID_EX_STATS_EN.
module id_ex_stage #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned REG_IDX_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [REG_IDX_W-1:0] in_rs1_idx,
    input  logic [REG_IDX_W-1:0] in_rs2_idx,
    input  logic [REG_IDX_W-1:0] in_rd_idx,
    input  logic [XLEN-1:0]      in_rs1_val,
    input  logic [XLEN-1:0]      in_rs2_val,
    input  logic [XLEN-1:0]      in_imm,
    input  logic                 in_use_imm,
    input  logic [2:0]           in_op,
    input  logic                 in_mod,
    input  logic                 in_operand_2_neg,
    input  logic                 in_reg_write,
    input  logic                 mem_fwd_en,
    input  logic [REG_IDX_W-1:0] mem_fwd_rd,
    input  logic [XLEN-1:0]      mem_fwd_val,
    input  logic                 wb_fwd_en,
    input  logic [REG_IDX_W-1:0] wb_fwd_rd,
    input  logic [XLEN-1:0]      wb_fwd_val,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_rs1_val,
    output logic [XLEN-1:0]      out_rs2_val,
    output logic [XLEN-1:0]      out_imm,
    output logic                 out_use_imm,
    output logic [2:0]           out_op,
    output logic                 out_mod,
    output logic                 out_operand_2_neg,
    output logic [REG_IDX_W-1:0] out_rd_idx,
    output logic                 out_reg_write,
    output logic [31:0]          stall_cnt,
    output logic [31:0]          flush_cnt
);

    logic [REG_IDX_W-1:0] rs1_idx_q;
    logic [REG_IDX_W-1:0] rs2_idx_q;
    logic                 capture;
    logic                 snoop_rs1;
    logic                 snoop_rs2;
    logic [XLEN-1:0]      rs1_byp;
    logic [XLEN-1:0]      rs2_byp;

    // x0 reads as zero; MEM is younger than WB so it wins
    function automatic logic [XLEN-1:0] resolve(
        input logic [REG_IDX_W-1:0] idx,
        input logic [XLEN-1:0]      rf_val,
        input logic                 m_en,
        input logic [REG_IDX_W-1:0] m_rd,
        input logic [XLEN-1:0]      m_val,
        input logic                 w_en,
        input logic [REG_IDX_W-1:0] w_rd,
        input logic [XLEN-1:0]      w_val
    );
        logic [XLEN-1:0] r;
        r = rf_val;
        if (idx == '0)                  r = '0;
        else if (m_en && (m_rd == idx)) r = m_val;
        else if (w_en && (w_rd == idx)) r = w_val;
        return r;
    endfunction

    always_comb begin
        in_ready  = !out_valid || out_ready;
        capture   = in_valid && in_ready && !flush;
        rs1_byp   = resolve(in_rs1_idx, in_rs1_val, mem_fwd_en, mem_fwd_rd, mem_fwd_val,
                            wb_fwd_en, wb_fwd_rd, wb_fwd_val);
        rs2_byp   = resolve(in_rs2_idx, in_rs2_val, mem_fwd_en, mem_fwd_rd, mem_fwd_val,
                            wb_fwd_en, wb_fwd_rd, wb_fwd_val);
        snoop_rs1 = out_valid && wb_fwd_en && (rs1_idx_q != '0) && (wb_fwd_rd == rs1_idx_q);
        snoop_rs2 = out_valid && wb_fwd_en && (rs2_idx_q != '0) && (wb_fwd_rd == rs2_idx_q);
    end

    // Flush beats capture; capture beats consume and snoop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid         <= 1'b0;
            out_rs1_val       <= '0;
            out_rs2_val       <= '0;
            out_imm           <= '0;
            out_use_imm       <= 1'b0;
            out_op            <= '0;
            out_mod           <= 1'b0;
            out_operand_2_neg <= 1'b0;
            out_rd_idx        <= '0;
            out_reg_write     <= 1'b0;
            rs1_idx_q         <= '0;
            rs2_idx_q         <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid         <= 1'b1;
            out_rs1_val       <= rs1_byp;
            out_rs2_val       <= rs2_byp;
            out_imm           <= in_imm;
            out_use_imm       <= in_use_imm;
            out_op            <= in_op;
            out_mod           <= in_mod;
            out_operand_2_neg <= in_operand_2_neg;
            out_rd_idx        <= in_rd_idx;
            out_reg_write     <= in_reg_write;
            rs1_idx_q         <= in_rs1_idx;
            rs2_idx_q         <= in_rs2_idx;
        end else begin
            if (out_ready) out_valid <= 1'b0;
            if (snoop_rs1) out_rs1_val <= wb_fwd_val;
            if (snoop_rs2) out_rs2_val <= wb_fwd_val;
        end
    end

`ifdef ID_EX_STATS_EN
    // Wrapping event counters for back-pressure and redirect loss
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && !flush) stall_cnt <= stall_cnt + 32'(1);
            if (flush && out_valid)                flush_cnt <= flush_cnt + 32'(1);
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; counter expectations follow ID_EX_STATS_EN.
module tb_id_ex_stage;
    localparam int unsigned XLEN = 32;
    localparam int unsigned RW   = 5;

`ifdef ID_EX_STATS_EN
    localparam logic [31:0] STATS = 32'd1;
`else
    localparam logic [31:0] STATS = 32'd0;
`endif

    logic clk, rst_n, flush, in_valid, in_ready;
    logic [RW-1:0] in_rs1_idx, in_rs2_idx, in_rd_idx;
    logic [XLEN-1:0] in_rs1_val, in_rs2_val, in_imm;
    logic in_use_imm, in_mod, in_operand_2_neg, in_reg_write;
    logic [2:0] in_op;
    logic mem_fwd_en, wb_fwd_en;
    logic [RW-1:0] mem_fwd_rd, wb_fwd_rd;
    logic [XLEN-1:0] mem_fwd_val, wb_fwd_val;
    logic out_valid, out_ready;
    logic [XLEN-1:0] out_rs1_val, out_rs2_val, out_imm;
    logic out_use_imm, out_mod, out_operand_2_neg, out_reg_write;
    logic [2:0] out_op;
    logic [RW-1:0] out_rd_idx;
    logic [31:0] stall_cnt, flush_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    id_ex_stage #(.XLEN(XLEN), .REG_IDX_W(RW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx), .in_rd_idx(in_rd_idx),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
        .in_use_imm(in_use_imm), .in_op(in_op), .in_mod(in_mod),
        .in_operand_2_neg(in_operand_2_neg), .in_reg_write(in_reg_write),
        .mem_fwd_en(mem_fwd_en), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_val(mem_fwd_val),
        .wb_fwd_en(wb_fwd_en), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_val(wb_fwd_val),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_imm(out_imm),
        .out_use_imm(out_use_imm), .out_op(out_op), .out_mod(out_mod),
        .out_operand_2_neg(out_operand_2_neg), .out_rd_idx(out_rd_idx),
        .out_reg_write(out_reg_write), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        flush = 0; in_valid = 0;
        in_rs1_idx = '0; in_rs2_idx = '0; in_rd_idx = '0;
        in_rs1_val = '0; in_rs2_val = '0; in_imm = '0;
        in_use_imm = 0; in_op = '0; in_mod = 0; in_operand_2_neg = 0; in_reg_write = 0;
        mem_fwd_en = 0; mem_fwd_rd = '0; mem_fwd_val = '0;
        wb_fwd_en = 0; wb_fwd_rd = '0; wb_fwd_val = '0;
    endtask

    task automatic do_reset();
        clear_in();
        out_ready = 1;
        rst_n = 0;
        cycle();
        rst_n = 1;
        cycle();
    endtask

    task automatic present(input logic [RW-1:0] r1, input logic [XLEN-1:0] v1,
                           input logic [RW-1:0] r2, input logic [XLEN-1:0] v2);
        in_valid = 1;
        in_rs1_idx = r1; in_rs1_val = v1;
        in_rs2_idx = r2; in_rs2_val = v2;
    endtask

    task automatic test_reset();
        clear_in();
        out_ready = 0;
        rst_n = 0;
        #3;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %0b want 0", out_valid); end
        n_cmp++; if (out_rs1_val !== '0 || out_rs2_val !== '0 || out_imm !== '0) begin n_bad++;
            $display("FAIL reset_payload got %h %h %h want 0", out_rs1_val, out_rs2_val, out_imm); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        n_cmp++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin n_bad++;
            $display("FAIL reset_counters got %0d %0d want 0 0", stall_cnt, flush_cnt); end
        cycle();
        rst_n = 1;
        out_ready = 1;
        cycle();
    endtask

    task automatic test_basic();
        present(5'd3, 32'h10, 5'd4, 32'h20);
        in_rd_idx = 5'd9; in_imm = 32'h123; in_use_imm = 1; in_op = 3'd5; in_mod = 1;
        in_operand_2_neg = 1; in_reg_write = 1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL basic_ready_pre got %0b want 1", in_ready); end
        cycle();
        clear_in();
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid got %0b want 1", out_valid); end
        n_cmp++; if (out_rs1_val !== 32'h10 || out_rs2_val !== 32'h20) begin n_bad++;
            $display("FAIL basic_ops got %h %h want 10 20", out_rs1_val, out_rs2_val); end
        n_cmp++; if ({out_imm, out_use_imm, out_op, out_mod, out_operand_2_neg, out_rd_idx, out_reg_write}
                     !== {32'h123, 1'b1, 3'd5, 1'b1, 1'b1, 5'd9, 1'b1}) begin n_bad++;
            $display("FAIL basic_meta got %h %0b %0d %0b %0b %0d %0b want 123 1 5 1 1 9 1",
                     out_imm, out_use_imm, out_op, out_mod, out_operand_2_neg, out_rd_idx, out_reg_write); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL basic_ready_post got %0b want 1", in_ready); end
        cycle();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_consume got %0b want 0", out_valid); end
    endtask

    task automatic test_forward();
        present(5'd5, 32'h1, 5'd6, 32'h2);
        mem_fwd_en = 1; mem_fwd_rd = 5'd5; mem_fwd_val = 32'hAA;
        wb_fwd_en = 1;  wb_fwd_rd = 5'd5;  wb_fwd_val = 32'hBB;
        cycle();
        n_cmp++; if (out_rs1_val !== 32'hAA) begin n_bad++; $display("FAIL fwd_mem_priority got %h want aa", out_rs1_val); end
        n_cmp++; if (out_rs2_val !== 32'h2) begin n_bad++; $display("FAIL fwd_no_match got %h want 2", out_rs2_val); end
        present(5'd0, 32'h77, 5'd6, 32'h66);
        mem_fwd_en = 1; mem_fwd_rd = 5'd0; mem_fwd_val = 32'hAA;
        wb_fwd_en = 1;  wb_fwd_rd = 5'd6;  wb_fwd_val = 32'hCC;
        cycle();
        n_cmp++; if (out_rs1_val !== 32'h0) begin n_bad++; $display("FAIL fwd_x0 got %h want 0", out_rs1_val); end
        n_cmp++; if (out_rs2_val !== 32'hCC) begin n_bad++; $display("FAIL fwd_wb got %h want cc", out_rs2_val); end
        clear_in();
        cycle();
    endtask

    task automatic test_snoop();
        out_ready = 0;
        present(5'd2, 32'h22, 5'd7, 32'h1);
        cycle();
        clear_in();
        wb_fwd_en = 1; wb_fwd_rd = 5'd7; wb_fwd_val = 32'h55;
        mem_fwd_en = 1; mem_fwd_rd = 5'd2; mem_fwd_val = 32'h99;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL snoop_in_ready got %0b want 0", in_ready); end
        cycle();
        clear_in();
        n_cmp++; if (out_rs2_val !== 32'h55) begin n_bad++; $display("FAIL snoop_wb got %h want 55", out_rs2_val); end
        n_cmp++; if (out_rs1_val !== 32'h22) begin n_bad++; $display("FAIL snoop_no_mem got %h want 22", out_rs1_val); end
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL snoop_valid got %0b want 1", out_valid); end
        out_ready = 1;
        cycle();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL snoop_consume got %0b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 0;
        present(5'd1, 32'hA1, 5'd2, 32'hA2);
        cycle();
        out_ready = 1;
        present(5'd3, 32'hB1, 5'd4, 32'hB2);
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready got %0b want 1", in_ready); end
        cycle();
        clear_in();
        n_cmp++; if (out_valid !== 1'b1 || out_rs1_val !== 32'hB1 || out_rs2_val !== 32'hB2) begin n_bad++;
            $display("FAIL b2b_payload got %0b %h %h want 1 b1 b2", out_valid, out_rs1_val, out_rs2_val); end
        cycle();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drain got %0b want 0", out_valid); end
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 0;
        present(5'd1, 32'hF1, 5'd2, 32'hF2);
        cycle();
        out_ready = 1;
        present(5'd3, 32'hE1, 5'd4, 32'hE2);
        flush = 1;
        cycle();
        clear_in();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid got %0b want 0", out_valid); end
        n_cmp++; if (flush_cnt !== STATS) begin n_bad++; $display("FAIL flush_cnt got %0d want %0d", flush_cnt, STATS); end
        n_cmp++; if (stall_cnt !== 32'd0) begin n_bad++; $display("FAIL flush_stall_cnt got %0d want 0", stall_cnt); end
        cycle();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_lost got %0b want 0", out_valid); end
    endtask

    task automatic test_stall();
        do_reset();
        out_ready = 0;
        present(5'd1, 32'h5, 5'd2, 32'h6);
        cycle();
        clear_in();
        repeat (4) cycle();
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL stall_hold got %0b want 1", out_valid); end
        out_ready = 1;
        cycle();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stall_consume got %0b want 0", out_valid); end
        n_cmp++; if (stall_cnt !== 32'd4 * STATS) begin n_bad++;
            $display("FAIL stall_cnt got %0d want %0d", stall_cnt, 32'd4 * STATS); end
    endtask

    task automatic test_async_reset();
        out_ready = 0;
        present(5'd8, 32'h1234, 5'd9, 32'h5678);
        cycle();
        clear_in();
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL areset_pre got %0b want 1", out_valid); end
        #2;
        rst_n = 0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || out_rs1_val !== '0) begin n_bad++;
            $display("FAIL areset_async got %0b %h want 0 0", out_valid, out_rs1_val); end
        cycle();
        rst_n = 1;
        out_ready = 1;
        cycle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_forward();
        test_snoop();
        test_back_to_back();
        test_flush();
        test_stall();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
